// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_hazard_pkg
// Shared types and constants for the 5-stage pipeline hazard/stall controller.
//   hz_state_t  : controller FSM states
//   hz_ctrl_t   : bundle of the five pipeline control strobes
//   REG_ZERO    : index of the hard-wired zero register (never a hazard source)
//   WAIT_TIMEOUT_DEF : default data-memory wait watchdog limit
// -----------------------------------------------------------------------------
package riscv_hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hz_state_t;

    // Field order is fixed so the strobe patterns below read left to right.
    typedef struct packed {
        logic bubble;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_hold;
    } hz_ctrl_t;

    localparam int unsigned REG_ZERO         = 0;
    localparam int unsigned WAIT_TIMEOUT_DEF = 255;

    // Control patterns used by the FSM.
    localparam hz_ctrl_t CTRL_NONE = 5'b00000;
    localparam hz_ctrl_t CTRL_LU   = 5'b11010; // hold PC + IF/ID, bubble into EX
    localparam hz_ctrl_t CTRL_BR   = 5'b00110; // squash IF/ID and ID/EX, PC takes target
    localparam hz_ctrl_t CTRL_MEM  = 5'b11001; // freeze front end and EX/MEM

endpackage : riscv_hazard_pkg

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the hazard-detection inputs and pipeline-control outputs of
// hazard_stall_ctrl. clk/reset are kept as plain ports on the modules.
//   master : pipeline side (drives hazard inputs, receives control strobes)
//   slave  : hazard_stall_ctrl side
// stall_cycles/flush_count carry perf counts when HAZARD_PERF_CNT_EN is
// defined and are tied to 0 otherwise.
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             bubble;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_hold;
    logic             timeout_err;
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  bubble, ifid_hold, ifid_flush, idex_flush, exmem_hold,
               timeout_err, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output bubble, ifid_hold, ifid_flush, idex_flush, exmem_hold,
               timeout_err, stall_cycles, flush_count
    );
endinterface : hazard_stall_ctrl_if

// File: rtl/hazard_stall_ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// hazard_wait_timer
// Counts consecutive data-memory wait cycles for the stall controller.
//   clk, reset : core clock, async active-low reset
//   load_i     : start a new wait (count := 1)
//   inc_i      : another wait cycle elapsed
//   clear_i    : wait finished or abandoned (count := 0); wins over load/inc
//   expired_o  : count has reached WAIT_TIMEOUT
// -----------------------------------------------------------------------------
module hazard_wait_timer #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i) begin
            wait_cnt_d = '0;
        end else if (load_i) begin
            wait_cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired_o = (wait_cnt_q == CNT_W'(WAIT_TIMEOUT));

endmodule : hazard_wait_timer

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard/stall controller for the 5-stage RISC-V pipeline. Detects load-use
// hazards and EX-resolved taken branches, and freezes the pipeline during
// multi-cycle data-memory accesses with a watchdog that latches timeout_err.
//   clk    : core clock
//   reset  : asynchronous active-low reset; all outputs are 0 while low
//   hz     : hazard_stall_ctrl_if.slave (hazard inputs, control outputs)
// Parameters: REG_W, LU_BUBBLES (1 or 2), WAIT_TIMEOUT (2..65535).
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stall_cycles and
// flush_count performance counters; otherwise those outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int          REG_W        = 5,
    parameter int          LU_BUBBLES   = 1,
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  hz
);
    hz_state_t  state_q, state_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    logic       load_use;
    logic       mem_stall;
    logic       timer_load, timer_inc, timer_clear, timer_expired;

    hz_ctrl_t   ctrl;       // raw FSM strobes
    hz_ctrl_t   run_ctrl;   // RUN decision assuming no memory stall
    hz_state_t  run_next;
    logic [1:0] run_lu_cnt;

    assign load_use = hz.ex_mem_read
                    && (hz.ex_rd != REG_W'(REG_ZERO))
                    && ((hz.ex_rd == hz.id_rs1)
                        || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    assign mem_stall = hz.mem_req && !hz.mem_ready;

    // RUN evaluation with mem_stall = 0; reused when a memory wait completes
    // so a branch or load-use hazard held during the wait still takes effect.
    always_comb begin
        run_ctrl   = CTRL_NONE;
        run_next   = RUN;
        run_lu_cnt = 2'd0;
        if (hz.ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            run_ctrl = CTRL_BR;
        end else if (load_use) begin
            run_ctrl = CTRL_LU;
            if (LU_BUBBLES == 2) begin
                run_next   = LU_STALL;
                run_lu_cnt = 2'd1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        ctrl          = CTRL_NONE;
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        timeout_err_d = timeout_err_q;
        timer_load    = 1'b0;
        timer_inc     = 1'b0;
        timer_clear   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctrl       = CTRL_MEM;
                    state_d    = MEM_WAIT;
                    timer_load = 1'b1;
                end else begin
                    ctrl     = run_ctrl;
                    state_d  = run_next;
                    lu_cnt_d = run_lu_cnt;
                end
            end

            LU_STALL: begin
                if (mem_stall) begin
                    // lu_cnt stays non-zero so the stall resumes after the wait.
                    ctrl       = CTRL_MEM;
                    state_d    = MEM_WAIT;
                    timer_load = 1'b1;
                end else begin
                    ctrl = CTRL_LU;
                    if (lu_cnt_q >= 2'(LU_BUBBLES - 1)) begin
                        state_d  = RUN;
                        lu_cnt_d = 2'd0;
                    end else begin
                        lu_cnt_d = lu_cnt_q + 2'd1;
                    end
                end
            end

            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    ctrl = CTRL_MEM;
                    if (timer_expired) begin
                        state_d       = ERROR;
                        timeout_err_d = 1'b1;
                        timer_clear   = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end else begin
                    ctrl        = run_ctrl;
                    timer_clear = 1'b1;
                    if (lu_cnt_q != 2'd0) begin
                        state_d = LU_STALL;
                    end else begin
                        state_d  = run_next;
                        lu_cnt_d = run_lu_cnt;
                    end
                end
            end

            ERROR: begin
                ctrl = CTRL_MEM;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            lu_cnt_q      <= 2'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lu_cnt_q      <= lu_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    hazard_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timer_load),
        .inc_i     (timer_inc),
        .clear_i   (timer_clear),
        .expired_o (timer_expired)
    );

    // Outputs are gated by reset directly so they drop to 0 the moment reset
    // asserts, not only after the registers have cleared.
    assign hz.bubble      = reset && ctrl.bubble;
    assign hz.ifid_hold   = reset && ctrl.ifid_hold;
    assign hz.ifid_flush  = reset && ctrl.ifid_flush;
    assign hz.idex_flush  = reset && ctrl.idex_flush;
    assign hz.exmem_hold  = reset && ctrl.exmem_hold;
    assign hz.timeout_err = reset && timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (hz.bubble) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (hz.idex_flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 32'd0;
`endif

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl. Two instances share one stimulus:
//   dut_a : LU_BUBBLES = 1, WAIT_TIMEOUT = 4
//   dut_b : LU_BUBBLES = 2, WAIT_TIMEOUT = 4
// Inputs change on the falling edge; outputs are sampled 2 time units later,
// well before the next rising edge.
// Output vector order: {bubble, ifid_hold, ifid_flush, idex_flush,
//                       exmem_hold, timeout_err}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam logic [5:0] V_NONE = 6'b000000;
    localparam logic [5:0] V_LU   = 6'b110100;
    localparam logic [5:0] V_BR   = 6'b001100;
    localparam logic [5:0] V_MW   = 6'b110010;
    localparam logic [5:0] V_ER   = 6'b110011;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    hazard_stall_ctrl_if #(.REG_W(5)) hz_a ();
    hazard_stall_ctrl_if #(.REG_W(5)) hz_b ();

    hazard_stall_ctrl #(
        .REG_W        (5),
        .LU_BUBBLES   (1),
        .WAIT_TIMEOUT (4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_a)
    );

    hazard_stall_ctrl #(
        .REG_W        (5),
        .LU_BUBBLES   (2),
        .WAIT_TIMEOUT (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of stimulus, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic       mem_read,
                         input logic [4:0] rd,
                         input logic [4:0] rs1,
                         input logic [4:0] rs2,
                         input logic       uses_rs2,
                         input logic       br,
                         input logic       req,
                         input logic       rdy);
        hz_a.ex_mem_read     = mem_read;  hz_b.ex_mem_read     = mem_read;
        hz_a.ex_rd           = rd;        hz_b.ex_rd           = rd;
        hz_a.id_rs1          = rs1;       hz_b.id_rs1          = rs1;
        hz_a.id_rs2          = rs2;       hz_b.id_rs2          = rs2;
        hz_a.id_uses_rs2     = uses_rs2;  hz_b.id_uses_rs2     = uses_rs2;
        hz_a.ex_branch_taken = br;        hz_b.ex_branch_taken = br;
        hz_a.mem_req         = req;       hz_b.mem_req         = req;
        hz_a.mem_ready       = rdy;       hz_b.mem_ready       = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample both instances mid-cycle, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b);
        #2;
        chk_vec({tag, "_a"}, {hz_a.bubble, hz_a.ifid_hold, hz_a.ifid_flush,
                              hz_a.idex_flush, hz_a.exmem_hold, hz_a.timeout_err}, exp_a);
        chk_vec({tag, "_b"}, {hz_b.bubble, hz_b.ifid_hold, hz_b.ifid_flush,
                              hz_b.idex_flush, hz_b.exmem_hold, hz_b.timeout_err}, exp_b);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        // A live load-use hazard during reset must not reach the outputs.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cyc("reset_gated", V_NONE, V_NONE);
        reset = 1'b1;

        // Load-use via rs1: one bubble for A, two for B.
        cyc("lu_rs1", V_LU, V_LU);
        idle();
        cyc("lu_rs1_after1", V_NONE, V_LU);
        cyc("lu_rs1_after2", V_NONE, V_NONE);

        // Load into x0 never stalls.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_x0", V_NONE, V_NONE);

        // rs2 match only counts when the instruction reads rs2.
        drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2_unused", V_NONE, V_NONE);
        drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2_used", V_LU, V_LU);
        idle();
        cyc("lu_rs2_after1", V_NONE, V_LU);
        cyc("lu_rs2_after2", V_NONE, V_NONE);

        // Branch beats load-use; no stall follows even with LU_BUBBLES = 2.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("br_lu", V_BR, V_BR);
        idle();
        cyc("br_lu_after", V_NONE, V_NONE);

        // Three wait cycles, released on the ready cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("mw_1", V_MW, V_MW);
        cyc("mw_2", V_MW, V_MW);
        cyc("mw_3", V_MW, V_MW);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("mw_ready", V_NONE, V_NONE);
        idle();
        cyc("mw_after", V_NONE, V_NONE);

        // Branch held in EX during a wait flushes on the ready cycle.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("mw_br_1", V_MW, V_MW);
        cyc("mw_br_2", V_MW, V_MW);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("mw_br_ready", V_BR, V_BR);
        idle();
        cyc("mw_br_after", V_NONE, V_NONE);

        // Memory stall arriving in LU_STALL: B resumes its second bubble
        // after the wait, A has no pending bubble.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_mw_hazard", V_LU, V_LU);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("lu_mw_wait", V_MW, V_MW);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("lu_mw_ready", V_NONE, V_NONE);
        idle();
        cyc("lu_mw_resume", V_NONE, V_LU);
        cyc("lu_mw_done", V_NONE, V_NONE);

        // Watchdog: RUN entry loads 1, then counts 1..4; at 4 with no ready
        // the controller enters ERROR.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("to_1", V_MW, V_MW);
        cyc("to_2", V_MW, V_MW);
        cyc("to_3", V_MW, V_MW);
        cyc("to_4", V_MW, V_MW);
        cyc("to_5", V_MW, V_MW);
        cyc("to_err", V_ER, V_ER);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("to_frozen", V_ER, V_ER);

        // Reset mid-operation clears everything immediately.
        reset = 1'b0;
        cyc("to_reset", V_NONE, V_NONE);
        reset = 1'b1;
        idle();
        cyc("to_after_reset", V_NONE, V_NONE);

        // Perf counters: load-use stall, then three wait cycles.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("perf_lu", V_LU, V_LU);
        idle();
        cyc("perf_lu_after", V_NONE, V_LU);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("perf_mw_1", V_MW, V_MW);
        cyc("perf_mw_2", V_MW, V_MW);
        cyc("perf_mw_3", V_MW, V_MW);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("perf_ready", V_NONE, V_NONE);
        idle();
`ifdef HAZARD_PERF_CNT_EN
        chk_32("perf_stall_a", hz_a.stall_cycles, 32'd4);
        chk_32("perf_flush_a", hz_a.flush_count,  32'd1);
        chk_32("perf_stall_b", hz_b.stall_cycles, 32'd5);
        chk_32("perf_flush_b", hz_b.flush_count,  32'd2);
`else
        chk_32("perf_stall_a", hz_a.stall_cycles, 32'd0);
        chk_32("perf_flush_a", hz_a.flush_count,  32'd0);
        chk_32("perf_stall_b", hz_b.stall_cycles, 32'd0);
        chk_32("perf_flush_b", hz_b.flush_count,  32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
